// File: rtl/mdu_issue_pkg.sv
// Shared constants for the M-extension issue controller: funct3 op codes,
// FSM state encoding and the MDU response timeout limit.
package mdu_issue_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [5:0] TMO_LIMIT = 6'd63;
   // Last counter value before the timeout fires; err lands TMO_LIMIT cycles after entry.
   localparam logic [5:0] TMO_LAST  = TMO_LIMIT - 6'd1;

endpackage

// File: rtl/mdu_issue_if.sv
// Core-side request/response and MDU-side handshake bundle of mdu_issue.
// slave is the controller's view, master the view of the core plus MDU around it.
interface mdu_issue_if;

   logic        req_valid;
   logic [2:0]  req_funct3;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic [4:0]  req_rd;
   logic        flush;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_rd;
   logic        err;
   logic        mdu_start;
   logic [2:0]  mdu_operation;
   logic [31:0] mdu_x;
   logic [31:0] mdu_y;
   logic        mdu_done;
   logic [31:0] mdu_result;

   modport slave (
      input  req_valid, req_funct3, req_rs1, req_rs2, req_rd, flush,
      input  mdu_done, mdu_result,
      output stall, rsp_valid, rsp_data, rsp_rd, err,
      output mdu_start, mdu_operation, mdu_x, mdu_y
   );

   modport master (
      output req_valid, req_funct3, req_rs1, req_rs2, req_rd, flush,
      output mdu_done, mdu_result,
      input  stall, rsp_valid, rsp_data, rsp_rd, err,
      input  mdu_start, mdu_operation, mdu_x, mdu_y
   );

endinterface

// File: rtl/mdu_bypass_check.sv
// Detects the divide/remainder corner cases whose RISC-V result is fixed,
// so they can be answered without starting the MDU.
module mdu_bypass_check
   import mdu_issue_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic        bypass,
   output logic [31:0] result
);

   always_comb begin
      bypass = 1'b0;
      result = '0;
      if (y == 32'h0000_0000) begin
         case (funct3)
            F3_DIV, F3_DIVU: begin
               bypass = 1'b1;
               result = 32'hFFFF_FFFF;
            end
            F3_REM, F3_REMU: begin
               bypass = 1'b1;
               result = x;
            end
            default: ;
         endcase
      end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         // Signed overflow: quotient wraps to the dividend, remainder is zero.
         case (funct3)
            F3_DIV: begin
               bypass = 1'b1;
               result = 32'h8000_0000;
            end
            F3_REM: begin
               bypass = 1'b1;
               result = 32'h0000_0000;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mdu_issue.sv
// Issue/handshake controller between the core execute stage and the MDU.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | accept a request; bypass cases answered here directly
//   ST_ISSUE | mdu_start pulse with latched operands
//   ST_WAIT  | wait for mdu_done, then respond; timeout raises err
//   ST_DRAIN | flushed request still running in the MDU; discard result
module mdu_issue
   import mdu_issue_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   mdu_issue_if.slave bus
);

   state_t      state;
   logic [2:0]  op_q;
   logic [31:0] x_q;
   logic [31:0] y_q;
   logic [4:0]  rd_q;
   logic [5:0]  tmo_cnt;

   logic        bp_hit;
   logic [31:0] bp_result;
   logic        accept;

   mdu_bypass_check u_bypass (
      .funct3 (bus.req_funct3),
      .x      (bus.req_rs1),
      .y      (bus.req_rs2),
      .bypass (bp_hit),
      .result (bp_result)
   );

   assign accept = (state == ST_IDLE) && bus.req_valid && !bus.flush;

   // Stall must act in the same cycle the core presents the request.
   assign bus.stall = (state != ST_IDLE) || (accept && !bp_hit);

   assign bus.mdu_operation = op_q;
   assign bus.mdu_x         = x_q;
   assign bus.mdu_y         = y_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         op_q          <= '0;
         x_q           <= '0;
         y_q           <= '0;
         rd_q          <= '0;
         tmo_cnt       <= '0;
         bus.mdu_start <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_rd    <= '0;
         bus.err       <= 1'b0;
      end else begin
         bus.mdu_start <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.err       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q <= bus.req_funct3;
                  x_q  <= bus.req_rs1;
                  y_q  <= bus.req_rs2;
                  rd_q <= bus.req_rd;
                  if (bp_hit) begin
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_data  <= bp_result;
                     bus.rsp_rd    <= bus.req_rd;
                  end else begin
                     bus.mdu_start <= 1'b1;
                     state         <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               tmo_cnt <= '0;
               state   <= bus.flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.flush) begin
                  tmo_cnt <= '0;
                  state   <= bus.mdu_done ? ST_IDLE : ST_DRAIN;
               end else if (bus.mdu_done) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_data  <= bus.mdu_result;
                  bus.rsp_rd    <= rd_q;
                  state         <= ST_IDLE;
               end else if (tmo_cnt == TMO_LAST) begin
                  bus.err <= 1'b1;
                  tmo_cnt <= TMO_LIMIT;
                  state   <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 6'd1;
               end
            end
            ST_DRAIN: begin
               if (bus.mdu_done) begin
                  state <= ST_IDLE;
               end else if (tmo_cnt == TMO_LAST) begin
                  bus.err <= 1'b1;
                  tmo_cnt <= TMO_LIMIT;
                  state   <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 6'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mdu_issue.md
MDU_ISSUE -- requirements
Module: mdu_issue

Interface
REQ-001 clk  in  1  single core clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 req_valid  in  1  M-extension instruction present in execute.
REQ-004 req_funct3  in  3  op code: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
REQ-005 req_rs1, req_rs2  in  32 each  operands X, Y.
REQ-006 req_rd  in  5  destination register index.
REQ-007 flush  in  1  pipeline flush; abort current request.
REQ-008 stall  out  1  hold the core pipeline.
REQ-009 rsp_valid  out  1  one-cycle pulse; rsp_data/rsp_rd valid.
REQ-010 rsp_data  out  32  result; rsp_rd  out  5  destination index.
REQ-011 err  out  1  one-cycle pulse on MDU timeout.
REQ-012 mdu_start  out  1; mdu_operation  out  3; mdu_x, mdu_y  out  32 each: drive the MDU.
REQ-013 mdu_done  in  1; mdu_result  in  32: from the MDU.

Function
REQ-014 States: IDLE, ISSUE, WAIT, DRAIN; reset state IDLE.
REQ-015 IDLE, req_valid=1, flush=0: latch funct3, rs1, rs2 and rd into internal registers; go to ISSUE, or stay IDLE on bypass (REQ-019).
REQ-016 ISSUE: mdu_start=1 for exactly this cycle; next state WAIT.
REQ-017 mdu_operation, mdu_x and mdu_y come only from the latched registers; they stay stable from ISSUE until the cycle after mdu_done, because the MDU samples them throughout.
REQ-018 WAIT: on mdu_done=1, register mdu_result into rsp_data; rsp_valid=1 on the following cycle; next state IDLE.
REQ-019 Bypass, decided in IDLE with no MDU start: DIV or DIVU with Y=0 gives 0xFFFFFFFF; REM or REMU with Y=0 gives X; DIV with X=0x80000000 and Y=0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0. rsp_valid=1 on the next cycle.
REQ-020 stall=1 in ISSUE, WAIT and DRAIN, and in IDLE when req_valid=1, flush=0 and the request is not a bypass; otherwise stall=0.
REQ-021 flush in IDLE: the request is not accepted and no rsp_valid follows; a pending bypass rsp_valid already registered is still emitted.
REQ-022 flush in ISSUE or WAIT: go to DRAIN (from ISSUE, still drive mdu_start first); no rsp_valid is produced for that request.
REQ-023 DRAIN: hold operands and wait for mdu_done, discard mdu_result, then go to IDLE; flush in DRAIN has no effect.
REQ-024 flush and mdu_done in the same WAIT cycle: flush wins, result is discarded, next state IDLE.
REQ-025 mdu_done in IDLE: ignored.
REQ-026 6-bit timeout counter clears on entering WAIT or DRAIN and increments each cycle there; at 63, err=1 for one cycle, state goes to IDLE, no rsp_valid.
REQ-027 Back-to-back requests are allowed: a new request may be accepted in IDLE during the same cycle rsp_valid is high.
REQ-028 rsp_rd equals the latched rd; rd=0 is still executed and responded.

Reset
REQ-029 While reset=0: state IDLE; stall=0, rsp_valid=0, err=0, mdu_start=0; rsp_data, rsp_rd, mdu_operation, mdu_x, mdu_y, latched registers and timeout counter all 0.
REQ-030 Reset mid-operation aborts with no response; the MDU is reset by the same reset net.

Structure
REQ-031 A shared package holds the funct3 op constants, the state encoding, and timeout limit 63.
REQ-032 One combinational sub-module, mdu_bypass_check, takes funct3, X and Y and returns a bypass flag and a 32-bit bypass result.

Verification
REQ-033 MUL, X=7, Y=6 -> one mdu_start pulse; rsp_valid one cycle after mdu_done, rsp_data=42; stall low the cycle rsp_valid is high.
REQ-034 DIV, X=0xFFFFFFF9 (-7), Y=2 -> rsp_data=0xFFFFFFFD; stall high through the ~33-cycle divide; mdu_x and mdu_y constant throughout.
REQ-035 DIVU, Y=0 -> no mdu_start, rsp_valid next cycle, rsp_data=0xFFFFFFFF; REM, X=0x80000000, Y=0xFFFFFFFF -> rsp_data=0.
REQ-036 DIV 100/3, flush in WAIT -> DRAIN until mdu_done; no rsp_valid; next MUL 3*3 returns 9.
REQ-037 mdu_done held low -> err pulse 63 cycles after entering WAIT; state IDLE; stall released.
REQ-038 reset asserted in WAIT -> all outputs 0 asynchronously; after release, MULHU 0xFFFFFFFF*2 returns 0x00000001.
